// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Arbiter FSM states, requester indices, state helper.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  function automatic arb_state_t own_of(
    input logic idx
  );
    return idx ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/dmem_arbiter_lock_timer.sv
// Saturating lock-hold counter for the arbiter.
// Ports: clk, reset (async low), clear, enable -> expired.
module lock_timer #(
  parameter int MAX_LOCK = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_LOCK - 1);
  localparam logic [CW-1:0] SAT  = CW'(MAX_LOCK);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && cnt != SAT) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Fires during the final owned cycle so the owner
  // holds the bus for exactly MAX_LOCK cycles.
  assign expired = enable && (cnt >= LAST);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bus lock sharing dmem.
// Ports: req/we/lock/addr/wdata per requester, gnt/rvalid/rdata, mem_*.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  arb_state_t state;
  arb_state_t state_nx;

  logic last;
  logic last_nx;
  logic cool;
  logic cool_nx;
  logic g0;
  logic g1;
  logic acc;
  logic sel;
  logic sel_lock;
  logic clear;
  logic expired;
  logic owning;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 && req1) begin
          g0 = last;
          g1 = ~last;
        end else begin
          g0 = req0;
          g1 = req1;
        end
      end
      OWN0:    g0 = req0;
      OWN1:    g1 = req1;
      default: ;
    endcase
  end

  assign gnt0     = g0 && reset;
  assign gnt1     = g1 && reset;
  assign acc      = gnt0 || gnt1;
  assign sel      = gnt1;
  assign sel_lock = sel ? lock1 : lock0;
  assign owning   = (state != IDLE);

  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    unique case (1'b1)
      gnt0: begin
        mem_we = we0;
        mem_a  = addr0;
        mem_wd = wdata0;
      end
      gnt1: begin
        mem_we = we1;
        mem_a  = addr1;
        mem_wd = wdata1;
      end
      default: ;
    endcase
  end

  // cool marks the IDLE cycle right after a timeout;
  // the evicted requester (== last) cannot re-lock in it.
  always_comb begin
    state_nx = state;
    last_nx  = last;
    cool_nx  = 1'b0;
    clear    = 1'b0;
    if (acc) begin
      last_nx = sel;
    end
    unique case (state)
      IDLE: begin
        if (acc && sel_lock &&
            !(cool && sel == last)) begin
          state_nx = own_of(sel);
          clear    = 1'b1;
        end
      end
      OWN0: begin
        if (!lock0 || expired) begin
          state_nx = IDLE;
        end
        if (expired) begin
          last_nx = REQ_CPU;
          cool_nx = lock0;
        end
      end
      OWN1: begin
        if (!lock1 || expired) begin
          state_nx = IDLE;
        end
        if (expired) begin
          last_nx = REQ_DMA;
          cool_nx = lock1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  lock_timer #(
    .MAX_LOCK(MAX_LOCK)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .enable (owning),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      last    <= REQ_DMA;
      cool    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      state   <= state_nx;
      last    <= last_nx;
      cool    <= cool_nx;
      rvalid0 <= gnt0 && !we0;
      rvalid1 <= gnt1 && !we1;
      if (gnt0 && !we0) begin
        rdata0 <= mem_rd;
      end
      if (gnt1 && !we1) begin
        rdata1 <= mem_rd;
      end
    end
  end

endmodule
